// File: rtl/dot_accum16.sv
// Saturating signed dot-product accumulator fed by a stream of 16-bit products.
// Holds each vector's sum, term count and sticky clamp flag on an output handshake.
module dot_accum16 #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat_flag;

  logic             accept;
  logic             handshake;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_wide;
  logic             overflow;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    in_ready  = (state == ACCUM) ? !clear : (out_ready && !clear);
    accept    = in_valid && in_ready;
    handshake = out_valid && out_ready;
    prod_ext  = {{(ACC_W-16){in_product[15]}}, in_product};
    sum_wide  = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    // The two top bits of the one-bit-wider sum disagree exactly on overflow
    overflow  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    if (!overflow)
      acc_next = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W])
      acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    else
      acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    cnt_next  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc      <= acc_next;
            cnt      <= cnt_next;
            sat_flag <= sat_flag | overflow;
            if (in_last) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (handshake) begin
            // A beat accepted alongside the handshake opens the next vector
            if (accept) begin
              acc      <= prod_ext;
              cnt      <= CNT_W'(1);
              sat_flag <= 1'b0;
              if (in_last) begin
                state     <= DONE;
                out_valid <= 1'b1;
              end else begin
                state     <= ACCUM;
                out_valid <= 1'b0;
              end
            end else begin
              acc       <= '0;
              cnt       <= '0;
              sat_flag  <= 1'b0;
              state     <= ACCUM;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ACCUM;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_sat   = sat_flag;

endmodule

// File: tb/tb_dot_accum16.sv
// Directed and randomized checks of dot_accum16 against a queue-based vector model,
// run on three parameterisations sharing one stimulus stream.
module tb_dot_accum16;

    logic clock = 1'b0;
    logic reset;
    logic clear;
    logic in_valid;
    logic [15:0] in_product;
    logic in_last;
    logic out_ready;

    logic rdy24, rdy17, rdyc2;
    logic ov24, ov17, ovc2;
    logic signed [23:0] sum24;
    logic signed [16:0] sum17;
    logic signed [23:0] sumc2;
    logic [7:0] cnt24, cnt17;
    logic [1:0] cntc2;
    logic sat24, sat17, satc2;

    int n_tests = 0;
    int n_fail = 0;

    int q[$];
    int res[$];
    bit exp_valid = 1'b0;

    always #5 clock = ~clock;

    dot_accum16 #(.ACC_W(24), .CNT_W(8)) u24 (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy24),
        .in_product(in_product), .in_last(in_last), .out_valid(ov24), .out_ready(out_ready),
        .out_sum(sum24), .out_count(cnt24), .out_sat(sat24));

    dot_accum16 #(.ACC_W(17), .CNT_W(8)) u17 (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy17),
        .in_product(in_product), .in_last(in_last), .out_valid(ov17), .out_ready(out_ready),
        .out_sum(sum17), .out_count(cnt17), .out_sat(sat17));

    dot_accum16 #(.ACC_W(24), .CNT_W(2)) uc2 (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdyc2),
        .in_product(in_product), .in_last(in_last), .out_valid(ovc2), .out_ready(out_ready),
        .out_sum(sumc2), .out_count(cntc2), .out_sat(satc2));

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Running saturating sum over the held vector, clamped after every term
    task automatic eval(input int accw, input int cntw,
                        output longint s, output longint c, output longint st);
        longint hi, lo;
        hi = (longint'(1) <<< (accw - 1)) - 1;
        lo = -(longint'(1) <<< (accw - 1));
        s = 0;
        st = 0;
        foreach (res[i]) begin
            s = s + res[i];
            if (s > hi) begin s = hi; st = 1; end
            if (s < lo) begin s = lo; st = 1; end
        end
        c = (res.size() > (1 << cntw) - 1) ? (1 << cntw) - 1 : res.size();
    endtask

    task automatic check_outputs();
        longint s, c, st;
        chk("out_valid24", longint'(ov24), longint'(exp_valid));
        chk("out_valid17", longint'(ov17), longint'(exp_valid));
        chk("out_validc2", longint'(ovc2), longint'(exp_valid));
        if (exp_valid) begin
            eval(24, 8, s, c, st);
            chk("sum24", longint'(sum24), s);
            chk("count24", longint'(cnt24), c);
            chk("sat24", longint'(sat24), st);
            eval(17, 8, s, c, st);
            chk("sum17", longint'(sum17), s);
            chk("count17", longint'(cnt17), c);
            chk("sat17", longint'(sat17), st);
            eval(24, 2, s, c, st);
            chk("sumc2", longint'(sumc2), s);
            chk("countc2", longint'(cntc2), c);
            chk("satc2", longint'(satc2), st);
        end
    endtask

    // One clock: drive inputs, check readiness, advance the model, check outputs
    task automatic step(input bit v, input int p, input bit l, input bit ordy, input bit clr,
                        output bit accepted);
        bit exp_ready;
        in_valid = v;
        in_product = p[15:0];
        in_last = l;
        out_ready = ordy;
        clear = clr;
        exp_ready = !clr && (!exp_valid || ordy);
        #1;
        chk("in_ready24", longint'(rdy24), longint'(exp_ready));
        chk("in_ready17", longint'(rdy17), longint'(exp_ready));
        chk("in_readyc2", longint'(rdyc2), longint'(exp_ready));
        accepted = v && exp_ready;
        if (clr) begin
            q.delete();
            exp_valid = 1'b0;
        end else begin
            if (exp_valid && ordy) exp_valid = 1'b0;
            if (accepted) begin
                q.push_back(p);
                if (l) begin
                    res = q;
                    q.delete();
                    exp_valid = 1'b1;
                end
            end
        end
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic beat(input int p, input bit l);
        bit a;
        step(1'b1, p, l, 1'b1, 1'b0, a);
    endtask

    task automatic idle(input bit ordy);
        bit a;
        step(1'b0, 0, 1'b0, ordy, 1'b0, a);
    endtask

    initial begin
        bit a;
        int len, p, tries;
        reset = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        in_product = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("reset_valid", longint'(ov24), 0);
        chk("reset_sum", longint'(sum24), 0);
        chk("reset_count", longint'(cnt24), 0);
        chk("reset_sat", longint'(sat24), 0);
        #10 reset = 1'b0;
        @(posedge clock);
        #1;

        // basic vector
        beat(100, 0);
        beat(-50, 0);
        beat(16384, 1);
        chk("basic_sum", longint'(sum24), 16434);
        chk("basic_count", longint'(cnt24), 3);
        idle(1'b1);

        // positive and negative saturation
        for (int i = 0; i < 5; i++) beat(16384, i == 4);
        chk("satp_sum17", longint'(sum17), 65535);
        chk("satp_flag17", longint'(sat17), 1);
        chk("satp_count17", longint'(cnt17), 5);
        idle(1'b1);
        for (int i = 0; i < 5; i++) beat(-16384, i == 4);
        chk("satn_sum17", longint'(sum17), -65536);
        chk("satn_flag17", longint'(sat17), 1);
        idle(1'b1);

        // backpressure, then back-to-back single-term vector
        beat(7, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 99, 1'b1, 1'b0, 1'b0, a);
        chk("bp_sum", longint'(sum24), 7);
        step(1'b1, -3, 1'b1, 1'b1, 1'b0, a);
        chk("b2b_sum", longint'(sum24), -3);
        chk("b2b_count", longint'(cnt24), 1);
        chk("b2b_valid", longint'(ov24), 1);
        idle(1'b1);

        // clear mid-vector
        beat(1000, 0);
        beat(2000, 0);
        step(1'b1, 5, 1'b0, 1'b1, 1'b1, a);
        beat(9, 1);
        chk("clear_sum", longint'(sum24), 9);
        chk("clear_count", longint'(cnt24), 1);
        idle(1'b1);

        // count saturation
        for (int i = 0; i < 6; i++) beat(1, i == 5);
        chk("cntsat_count", longint'(cntc2), 3);
        chk("cntsat_sum", longint'(sumc2), 6);
        chk("cntsat_flag", longint'(satc2), 0);
        idle(1'b1);

        // randomized vectors with random backpressure and occasional clear
        for (int v = 0; v < 60; v++) begin
            len = $urandom_range(1, 7);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 2) == 0)
                    p = ($urandom_range(0, 1) == 1) ? 32767 - $urandom_range(0, 64)
                                                   : -32768 + $urandom_range(0, 64);
                else
                    p = $signed(16'($urandom));
                tries = 0;
                a = 1'b0;
                while (!a && tries < 200) begin
                    step(1'b1, p, b == len - 1, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 40) == 0, a);
                    tries++;
                end
                chk("accept_budget", longint'(a), 1);
            end
            if ($urandom_range(0, 1) == 1) step(1'b0, 0, 1'b0, $urandom_range(0, 1) == 1, 1'b0, a);
        end
        idle(1'b1);

        // asynchronous reset while a result is held
        step(1'b1, 11, 1'b1, 1'b0, 1'b0, a);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("areset_valid24", longint'(ov24), 0);
        chk("areset_valid17", longint'(ov17), 0);
        q.delete();
        exp_valid = 1'b0;
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        beat(4, 1);
        chk("areset_sum", longint'(sum24), 4);
        chk("areset_count", longint'(cnt24), 1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
